// File: rtl/usb_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkg
// Shared USB definitions for the receive control unit (usb_rx_ctrl) and the
// transmit control unit (tcu): SYNC pattern, PID byte values, the encoding
// reported on rx_packet, and the CRC16 residue expected after a good packet.
// No ports; imported with "import usb_pkg::*".
// -----------------------------------------------------------------------------
package usb_pkg;

   localparam logic [7:0]  SYNC_BYTE           = 8'b1000_0000;
   localparam logic [7:0]  PID_DATA            = 8'h3C;
   localparam logic [7:0]  PID_ACK             = 8'h2D;
   localparam logic [7:0]  PID_NAK             = 8'hA5;

   // Residue left in the CRC16 register once the data bytes and both CRC
   // bytes have been accumulated.
   localparam logic [15:0] CRC_RESIDUE_DEFAULT = 16'h800D;

   typedef enum logic [1:0] {
      RX_NONE = 2'd0,
      RX_DATA = 2'd1,
      RX_ACK  = 2'd2,
      RX_NAK  = 2'd3
   } rx_packet_t;

endpackage

// File: rtl/usb_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// usb_rx_ctrl_if
// Groups the signals between usb_rx_ctrl and its neighbours.
//   From the bit-level receive path: d_edge, shift_enable, eop, byte_received,
//     rcv_data[7:0], crc_value[15:0]; from the receive FIFO: fifo_full.
//   Driven by the control unit: rcving, w_enable, w_data[7:0], crc_sync_rst,
//     crc_enable, rx_data_ready, rx_packet, rx_byte_count[6:0], r_error.
// Modports: slave = the control unit, master = its environment.
// -----------------------------------------------------------------------------
interface usb_rx_ctrl_if;
   import usb_pkg::*;

   logic        d_edge;
   logic        shift_enable;
   logic        eop;
   logic        byte_received;
   logic [7:0]  rcv_data;
   logic [15:0] crc_value;
   logic        fifo_full;

   logic        rcving;
   logic        w_enable;
   logic [7:0]  w_data;
   logic        crc_sync_rst;
   logic        crc_enable;
   logic        rx_data_ready;
   rx_packet_t  rx_packet;
   logic [6:0]  rx_byte_count;
   logic        r_error;

   modport master (
      output d_edge, shift_enable, eop, byte_received, rcv_data, crc_value, fifo_full,
      input  rcving, w_enable, w_data, crc_sync_rst, crc_enable, rx_data_ready,
             rx_packet, rx_byte_count, r_error
   );

   modport slave (
      input  d_edge, shift_enable, eop, byte_received, rcv_data, crc_value, fifo_full,
      output rcving, w_enable, w_data, crc_sync_rst, crc_enable, rx_data_ready,
             rx_packet, rx_byte_count, r_error
   );

endinterface

// File: rtl/usb_rx_holdback.sv
// -----------------------------------------------------------------------------
// usb_rx_holdback
// Two-deep byte shift buffer that delays payload bytes so the two trailing
// CRC bytes of a data packet never reach the FIFO.
//   clk, n_rst : clock, asynchronous active-low reset
//   push       : shift din in (the oldest byte drops out when already full)
//   flush      : empty the buffer (wins over push)
//   din[7:0]   : byte to push
//   full       : two bytes held
//   oldest[7:0]: the older held byte, i.e. the one a push while full evicts
// -----------------------------------------------------------------------------
module usb_rx_holdback (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       push,
   input  logic       flush,
   input  logic [7:0] din,
   output logic       full,
   output logic [7:0] oldest
);

   logic [7:0] oldest_q, oldest_d;
   logic [7:0] newer_q, newer_d;
   logic [1:0] count_q, count_d;

   always_comb begin
      oldest_d = oldest_q;
      newer_d  = newer_q;
      count_d  = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else if (push) begin
         case (count_q)
            2'd0: begin
               oldest_d = din;
               count_d  = 2'd1;
            end
            2'd1: begin
               newer_d = din;
               count_d = 2'd2;
            end
            default: begin
               oldest_d = newer_q;
               newer_d  = din;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         oldest_q <= 8'h00;
         newer_q  <= 8'h00;
         count_q  <= 2'd0;
      end else begin
         oldest_q <= oldest_d;
         newer_q  <= newer_d;
         count_q  <= count_d;
      end
   end

   assign full   = (count_q == 2'd2);
   assign oldest = oldest_q;

endmodule

// File: rtl/usb_rx_ctrl.sv
// -----------------------------------------------------------------------------
// usb_rx_ctrl
// USB receive control unit. Follows a packet from the line decoder, checks
// SYNC and PID, forwards data-phase payload to the receive FIFO while holding
// back the last two (CRC) bytes, and checks the CRC16 residue at EOP.
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : usb_rx_ctrl_if.slave (decoder/CRC/FIFO inputs, status and
//                FIFO write outputs; all outputs are registered)
// Parameters: MAX_DATA (payload byte limit), CRC_RESIDUE (good-packet CRC
//   residue), TIMEOUT_CYCLES (inter-byte idle limit).
// Build option: define USB_RX_TIMEOUT_EN to abort a packet that stalls for
//   TIMEOUT_CYCLES clocks; without it the FSM waits indefinitely.
// -----------------------------------------------------------------------------
module usb_rx_ctrl
   import usb_pkg::*;
#(
   parameter int          MAX_DATA       = 64,
   parameter logic [15:0] CRC_RESIDUE    = CRC_RESIDUE_DEFAULT,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input logic           clk,
   input logic           n_rst,
   usb_rx_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE, WAIT_SYNC, WAIT_PID, RCV_DATA, CHECK_CRC, WAIT_EOP, DONE, ERR
   } state_t;

   state_t     state_q, state_d;
   logic       rcving_q, rcving_d;
   logic       w_enable_q, w_enable_d;
   logic [7:0] w_data_q, w_data_d;
   logic       crc_sync_rst_q, crc_sync_rst_d;
   logic       crc_enable_q, crc_enable_d;
   logic       rx_data_ready_q, rx_data_ready_d;
   rx_packet_t rx_packet_q, rx_packet_d;
   logic [6:0] rx_byte_count_q, rx_byte_count_d;
   logic       r_error_q, r_error_d;
   logic [6:0] payload_cnt_q, payload_cnt_d;

   logic       eop_strobe;
   logic       hb_push, hb_flush, hb_full;
   logic [7:0] hb_oldest;
   logic       err_exit;

`ifdef USB_RX_TIMEOUT_EN
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               timed_out_q, timed_out_d;
`endif

   assign eop_strobe = bus.eop & bus.shift_enable;

   usb_rx_holdback u_holdback (
      .clk    (clk),
      .n_rst  (n_rst),
      .push   (hb_push),
      .flush  (hb_flush),
      .din    (bus.rcv_data),
      .full   (hb_full),
      .oldest (hb_oldest)
   );

   // Next-state and registered-output logic. A byte arriving together with an
   // EOP strobe is handled first; SE0 spans two bit times so the second strobe
   // still ends the packet.
   always_comb begin
      state_d         = state_q;
      rcving_d        = rcving_q;
      w_enable_d      = 1'b0;
      w_data_d        = w_data_q;
      crc_sync_rst_d  = 1'b0;
      crc_enable_d    = 1'b0;
      rx_data_ready_d = 1'b0;
      rx_packet_d     = rx_packet_q;
      rx_byte_count_d = rx_byte_count_q;
      r_error_d       = r_error_q;
      payload_cnt_d   = payload_cnt_q;
      hb_push         = 1'b0;
      hb_flush        = 1'b0;
      err_exit        = !bus.eop;
`ifdef USB_RX_TIMEOUT_EN
      if (timed_out_q) err_exit = 1'b1;
`endif

      case (state_q)
         IDLE: begin
            hb_flush = 1'b1;
            if (bus.d_edge) begin
               state_d        = WAIT_SYNC;
               rcving_d       = 1'b1;
               crc_sync_rst_d = 1'b1;
               r_error_d      = 1'b0;
               rx_packet_d    = RX_NONE;
               payload_cnt_d  = 7'd0;
            end
         end
         WAIT_SYNC: begin
            if (bus.byte_received)
               state_d = (bus.rcv_data == SYNC_BYTE) ? WAIT_PID : ERR;
            else if (eop_strobe)
               state_d = ERR;
         end
         // A packet that ends before its PID is as broken as a bad PID.
         WAIT_PID: begin
            if (bus.byte_received) begin
               case (bus.rcv_data)
                  PID_DATA: begin rx_packet_d = RX_DATA; state_d = RCV_DATA; end
                  PID_ACK:  begin rx_packet_d = RX_ACK;  state_d = WAIT_EOP; end
                  PID_NAK:  begin rx_packet_d = RX_NAK;  state_d = WAIT_EOP; end
                  default:  state_d = ERR;
               endcase
            end else if (eop_strobe) begin
               state_d = ERR;
            end
         end
         // Once two bytes are held, each new byte evicts the oldest into the
         // FIFO; a refused write aborts without touching buffer or count.
         RCV_DATA: begin
            if (bus.byte_received) begin
               if (hb_full && (bus.fifo_full || payload_cnt_q >= 7'(MAX_DATA))) begin
                  state_d = ERR;
               end else begin
                  hb_push      = 1'b1;
                  crc_enable_d = 1'b1;
                  if (hb_full) begin
                     w_enable_d    = 1'b1;
                     w_data_d      = hb_oldest;
                     payload_cnt_d = payload_cnt_q + 7'd1;
                  end
               end
            end else if (eop_strobe) begin
               state_d = hb_full ? CHECK_CRC : ERR;
            end
         end
         CHECK_CRC: begin
            if (bus.crc_value == CRC_RESIDUE) begin
               state_d         = DONE;
               rx_data_ready_d = 1'b1;
               rx_byte_count_d = payload_cnt_q;
               rcving_d        = 1'b0;
            end else begin
               state_d = ERR;
            end
         end
         WAIT_EOP: begin
            if (bus.byte_received) begin
               state_d = ERR;
            end else if (eop_strobe) begin
               state_d         = DONE;
               rx_data_ready_d = 1'b1;
               rx_byte_count_d = 7'd0;
               rcving_d        = 1'b0;
            end
         end
         DONE: state_d = IDLE;
         ERR: begin
            if (err_exit) begin
               state_d  = IDLE;
               rcving_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef USB_RX_TIMEOUT_EN
      // The idle timer only runs while the FSM is waiting for line activity.
      timer_d     = '0;
      timed_out_d = (state_q == IDLE) ? 1'b0 : timed_out_q;
      if ((state_q == WAIT_SYNC || state_q == WAIT_PID || state_q == RCV_DATA ||
           state_q == WAIT_EOP) && !bus.byte_received && state_d == state_q) begin
         if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
            state_d     = ERR;
            timed_out_d = 1'b1;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end
`endif

      if (state_d == ERR) r_error_d = 1'b1;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q         <= IDLE;
         rcving_q        <= 1'b0;
         w_enable_q      <= 1'b0;
         w_data_q        <= 8'h00;
         crc_sync_rst_q  <= 1'b0;
         crc_enable_q    <= 1'b0;
         rx_data_ready_q <= 1'b0;
         rx_packet_q     <= RX_NONE;
         rx_byte_count_q <= 7'd0;
         r_error_q       <= 1'b0;
         payload_cnt_q   <= 7'd0;
      end else begin
         state_q         <= state_d;
         rcving_q        <= rcving_d;
         w_enable_q      <= w_enable_d;
         w_data_q        <= w_data_d;
         crc_sync_rst_q  <= crc_sync_rst_d;
         crc_enable_q    <= crc_enable_d;
         rx_data_ready_q <= rx_data_ready_d;
         rx_packet_q     <= rx_packet_d;
         rx_byte_count_q <= rx_byte_count_d;
         r_error_q       <= r_error_d;
         payload_cnt_q   <= payload_cnt_d;
      end
   end

`ifdef USB_RX_TIMEOUT_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         timer_q     <= '0;
         timed_out_q <= 1'b0;
      end else begin
         timer_q     <= timer_d;
         timed_out_q <= timed_out_d;
      end
   end
`endif

   assign bus.rcving        = rcving_q;
   assign bus.w_enable      = w_enable_q;
   assign bus.w_data        = w_data_q;
   assign bus.crc_sync_rst  = crc_sync_rst_q;
   assign bus.crc_enable    = crc_enable_q;
   assign bus.rx_data_ready = rx_data_ready_q;
   assign bus.rx_packet     = rx_packet_q;
   assign bus.rx_byte_count = rx_byte_count_q;
   assign bus.r_error       = r_error_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usb_rx_ctrl
// Self-checking bench for usb_rx_ctrl: a table of whole packets with
// hand-computed results, followed by hand-written sequences for latency,
// d_edge clearing, mid-packet reset and (when USB_RX_TIMEOUT_EN is defined)
// the inter-byte timeout. The CRC unit is stood in for by driving crc_value
// with the residue it would hold for a good or a corrupted packet.
// -----------------------------------------------------------------------------
module tb_usb_rx_ctrl;

   logic clk = 1'b0;
   logic n_rst;

   usb_rx_ctrl_if bus ();

   usb_rx_ctrl dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0]  sync;
      int          nb;
      logic [47:0] bytes;
      bit          crc_ok;
      int          full_at;
      int          exp_writes;
      logic [23:0] exp_w;
      int          exp_ready;
      logic [1:0]  exp_pkt;
      logic [6:0]  exp_cnt;
      logic        exp_err;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] wr_log[$];
   int         rdy_total  = 0;
   int         assert_cnt = 0;
   int         fail_cnt   = 0;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Scoreboard side: log every FIFO write and count ready pulses, sampled
   // mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (bus.w_enable === 1'b1) wr_log.push_back(bus.w_data);
      if (bus.rx_data_ready === 1'b1) rdy_total++;
   end

   function automatic vec_t mk(input logic [7:0] sync, input int nb, input logic [47:0] b,
                               input bit crc_ok, input int full_at, input int nw,
                               input logic [23:0] w, input int rdy, input logic [1:0] pkt,
                               input logic [6:0] cnt, input logic err);
      vec_t v;
      v.sync = sync; v.nb = nb; v.bytes = b; v.crc_ok = crc_ok; v.full_at = full_at;
      v.exp_writes = nw; v.exp_w = w; v.exp_ready = rdy; v.exp_pkt = pkt;
      v.exp_cnt = cnt; v.exp_err = err;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      assert_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rcv_data      = b;
      bus.byte_received = 1'b1;
      bus.shift_enable  = 1'b1;
      tick();
      bus.byte_received = 1'b0;
      bus.shift_enable  = 1'b0;
   endtask

   // SE0 for two bit times: two eop strobes, then the line returns to idle.
   task automatic send_eop();
      bus.eop = 1'b1; bus.shift_enable = 1'b1;
      tick();
      bus.shift_enable = 1'b0;
      repeat (3) tick();
      bus.shift_enable = 1'b1;
      tick();
      bus.shift_enable = 1'b0; bus.eop = 1'b0;
      repeat (3) tick();
   endtask

   task automatic start_packet();
      bus.d_edge = 1'b1;
      tick();
      bus.d_edge = 1'b0;
      repeat (2) tick();
   endtask

   task automatic apply_stimulus(input vec_t v);
      bus.crc_value = v.crc_ok ? 16'h800D : 16'h1234;
      start_packet();
      send_byte(v.sync);
      repeat (3) tick();
      for (int i = 0; i < v.nb; i++) begin
         bus.fifo_full = (v.full_at >= 0 && i >= v.full_at);
         send_byte(v.bytes[47-8*i -: 8]);
         repeat (3) tick();
      end
      send_eop();
      bus.fifo_full = 1'b0;
   endtask

   task automatic check_output(input vec_t v, input int idx, input int wr_base, input int rdy_base);
      int nw;
      @(negedge clk);
      nw = wr_log.size() - wr_base;
      check_val($sformatf("v%0d_writes", idx), nw, v.exp_writes);
      for (int k = 0; k < nw && k < v.exp_writes; k++)
         check_val($sformatf("v%0d_wdata%0d", idx, k), wr_log[wr_base+k], v.exp_w[23-8*k -: 8]);
      check_val($sformatf("v%0d_ready", idx), rdy_total - rdy_base, v.exp_ready);
      check_val($sformatf("v%0d_rx_packet", idx), bus.rx_packet, v.exp_pkt);
      check_val($sformatf("v%0d_byte_count", idx), bus.rx_byte_count, v.exp_cnt);
      check_val($sformatf("v%0d_r_error", idx), bus.r_error, v.exp_err);
      check_val($sformatf("v%0d_rcving", idx), bus.rcving, 0);
   endtask

   initial begin
      int wb, rb;
      n_rst = 1'b0;
      bus.d_edge = 1'b0; bus.shift_enable = 1'b0; bus.eop = 1'b0;
      bus.byte_received = 1'b0; bus.rcv_data = 8'h00;
      bus.crc_value = 16'h0000; bus.fifo_full = 1'b0;

      //         sync   nb bytes (PID first)     crc fullAt wr  wdata       rdy pkt cnt err
      vecs.push_back(mk(8'h80, 6, 48'h3C11_2233_C1C2, 1, -1, 3, 24'h112233, 1, 1, 3, 0));
      vecs.push_back(mk(8'h80, 1, 48'h2D00_0000_0000, 1, -1, 0, 24'h000000, 1, 2, 0, 0));
      vecs.push_back(mk(8'h80, 1, 48'hA500_0000_0000, 1, -1, 0, 24'h000000, 1, 3, 0, 0));
      vecs.push_back(mk(8'h80, 3, 48'h3CC1_C200_0000, 1, -1, 0, 24'h000000, 1, 1, 0, 0));
      vecs.push_back(mk(8'h80, 2, 48'h3CAA_0000_0000, 1, -1, 0, 24'h000000, 0, 1, 0, 1));
      vecs.push_back(mk(8'h80, 5, 48'h3C44_55C1_C200, 0, -1, 2, 24'h445500, 0, 1, 0, 1));
      vecs.push_back(mk(8'h80, 1, 48'h2D00_0000_0000, 1, -1, 0, 24'h000000, 1, 2, 0, 0));
      vecs.push_back(mk(8'h80, 4, 48'h3C5A_C1C2_0000, 1, -1, 1, 24'h5A0000, 1, 1, 1, 0));
      vecs.push_back(mk(8'h81, 0, 48'h0000_0000_0000, 1, -1, 0, 24'h000000, 0, 0, 1, 1));
      vecs.push_back(mk(8'h80, 1, 48'h6900_0000_0000, 1, -1, 0, 24'h000000, 0, 0, 1, 1));
      vecs.push_back(mk(8'h80, 4, 48'h3C11_2233_0000, 1,  3, 0, 24'h000000, 0, 1, 1, 1));
      vecs.push_back(mk(8'h80, 2, 48'h2D00_0000_0000, 1, -1, 0, 24'h000000, 0, 2, 1, 1));

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_rcving", bus.rcving, 0);
      check_val("rst_w_enable", bus.w_enable, 0);
      check_val("rst_w_data", bus.w_data, 0);
      check_val("rst_crc_sync_rst", bus.crc_sync_rst, 0);
      check_val("rst_crc_enable", bus.crc_enable, 0);
      check_val("rst_ready", bus.rx_data_ready, 0);
      check_val("rst_rx_packet", bus.rx_packet, 0);
      check_val("rst_byte_count", bus.rx_byte_count, 0);
      check_val("rst_r_error", bus.r_error, 0);
      n_rst = 1'b1;
      tick();

      foreach (vecs[i]) begin
         wb = wr_log.size();
         rb = rdy_total;
         apply_stimulus(vecs[i]);
         check_output(vecs[i], i, wb, rb);
      end

      // d_edge after an error clears r_error/rx_packet and pulses crc_sync_rst;
      // then a one-byte payload with exact output timing.
      bus.crc_value = 16'h800D;
      bus.d_edge = 1'b1;
      tick();
      bus.d_edge = 1'b0;
      @(negedge clk);
      check_val("dedge_crc_sync_rst", bus.crc_sync_rst, 1);
      check_val("dedge_rcving", bus.rcving, 1);
      check_val("dedge_r_error", bus.r_error, 0);
      check_val("dedge_rx_packet", bus.rx_packet, 0);
      tick();
      @(negedge clk);
      check_val("dedge_crc_sync_rst_pulse", bus.crc_sync_rst, 0);
      send_byte(8'h80); repeat (3) tick();
      send_byte(8'h3C);
      @(negedge clk);
      check_val("pid_crc_enable", bus.crc_enable, 0);
      repeat (3) tick();
      send_byte(8'h77);
      @(negedge clk);
      check_val("b1_crc_enable", bus.crc_enable, 1);
      check_val("b1_w_enable", bus.w_enable, 0);
      repeat (3) tick();
      send_byte(8'hC1);
      @(negedge clk);
      check_val("b2_w_enable", bus.w_enable, 0);
      repeat (3) tick();
      send_byte(8'hC2);
      @(negedge clk);
      check_val("b3_crc_enable", bus.crc_enable, 1);
      check_val("b3_w_enable", bus.w_enable, 1);
      check_val("b3_w_data", bus.w_data, 8'h77);
      repeat (3) tick();
      bus.eop = 1'b1; bus.shift_enable = 1'b1;
      tick();
      bus.shift_enable = 1'b0;
      @(negedge clk);
      check_val("data_ready_lat1", bus.rx_data_ready, 0);
      tick();
      @(negedge clk);
      check_val("data_ready_lat2", bus.rx_data_ready, 1);
      check_val("data_byte_count", bus.rx_byte_count, 1);
      check_val("data_rcving_drop", bus.rcving, 0);
      tick();
      @(negedge clk);
      check_val("data_ready_pulse", bus.rx_data_ready, 0);
      bus.eop = 1'b0;
      repeat (3) tick();

      // Reset in the middle of the payload, coinciding with a byte that
      // would otherwise trigger a FIFO write.
      start_packet();
      send_byte(8'h80); repeat (3) tick();
      send_byte(8'h3C); repeat (3) tick();
      send_byte(8'h11); repeat (3) tick();
      send_byte(8'h22); repeat (3) tick();
      wb = wr_log.size();
      bus.rcv_data = 8'h33; bus.byte_received = 1'b1; bus.shift_enable = 1'b1;
      n_rst = 1'b0;
      tick();
      bus.byte_received = 1'b0; bus.shift_enable = 1'b0;
      @(negedge clk);
      check_val("mrst_w_enable", bus.w_enable, 0);
      check_val("mrst_rcving", bus.rcving, 0);
      check_val("mrst_crc_enable", bus.crc_enable, 0);
      check_val("mrst_rx_packet", bus.rx_packet, 0);
      check_val("mrst_byte_count", bus.rx_byte_count, 0);
      check_val("mrst_writes", wr_log.size() - wb, 0);
      n_rst = 1'b1;
      repeat (2) tick();

      // Handshake packet: ready one cycle after the accepting eop strobe.
      start_packet();
      send_byte(8'h80); repeat (3) tick();
      send_byte(8'h2D); repeat (3) tick();
      bus.eop = 1'b1; bus.shift_enable = 1'b1;
      tick();
      bus.shift_enable = 1'b0;
      @(negedge clk);
      check_val("hs_ready_lat1", bus.rx_data_ready, 1);
      check_val("hs_rx_packet", bus.rx_packet, 2);
      bus.eop = 1'b0;
      repeat (3) tick();

`ifdef USB_RX_TIMEOUT_EN
      // Stall after the PID: still waiting at 200 cycles, aborted by 300.
      start_packet();
      send_byte(8'h80); repeat (3) tick();
      send_byte(8'h3C);
      repeat (200) tick();
      @(negedge clk);
      check_val("to_early_r_error", bus.r_error, 0);
      repeat (100) tick();
      @(negedge clk);
      check_val("to_r_error", bus.r_error, 1);
      check_val("to_rcving", bus.rcving, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/usb_rx_ctrl.md
# usb_rx_ctrl

USB receive control unit: tracks an incoming packet from the line decoder and validates SYNC and PID. It writes data-phase payload bytes to the receive FIFO, holding back the trailing two CRC bytes, then checks the CRC16 residue at EOP. It sits between the bit-level receive path (edge detector, NRZI/stuff decoder, shift register, CRC16 unit) and the receive FIFO, mirroring `tcu` on the transmit side.

## Interface
Parameters:
- `MAX_DATA`, 64: maximum payload bytes per data packet; more is an error.
- `CRC_RESIDUE`, 16'h800D: CRC16 residue for a good packet (data plus CRC bytes).
- `TIMEOUT_CYCLES`, 255: inter-byte idle limit in clk cycles (used only with `USB_RX_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock
- `n_rst`  in  1  reset, asynchronous, active-low
- `d_edge`  in  1  line transition detected; starts a packet from IDLE
- `shift_enable`  in  1  one-cycle bit-time strobe
- `eop`  in  1  SE0 seen on line (level)
- `byte_received`  in  1  one-cycle pulse: `rcv_data` holds a new byte
- `rcv_data`  in  8  assembled byte
- `crc_value`  in  16  running CRC16 from CRC unit
- `fifo_full`  in  1  receive FIFO cannot accept a write
- `rcving`  out  1  packet in progress
- `w_enable`  out  1  one-cycle FIFO write strobe
- `w_data`  out  8  byte written to FIFO
- `crc_sync_rst`  out  1  clears CRC unit
- `crc_enable`  out  1  CRC unit accumulates the current byte
- `rx_data_ready`  out  1  one-cycle pulse: good packet finished
- `rx_packet`  out  2  0 none, 1 DATA, 2 ACK, 3 NAK
- `rx_byte_count`  out  7  payload bytes of last good packet
- `r_error`  out  1  sticky packet error

## Operation
- Reset: all outputs 0; state IDLE; holdback buffer empty; counters 0.
- Let `eop_strobe = eop & shift_enable`.
- IDLE: on `d_edge`, go to WAIT_SYNC. Assert `rcving` and `crc_sync_rst` for 1 cycle. Clear `r_error` and `rx_packet`.
- WAIT_SYNC: on `byte_received`, `rcv_data` == `SYNC_BYTE` (8'b10000000) goes to WAIT_PID; anything else goes to ERR. `eop_strobe` goes to ERR.
- WAIT_PID: on `byte_received`:
  - `PID_DATA` (8'h3C): set `rx_packet`=1, go to RCV_DATA.
  - `PID_ACK` (8'h2D) or `PID_NAK` (8'hA5): set 2 or 3, go to WAIT_EOP.
  - Any other PID: go to ERR.
- RCV_DATA, on each `byte_received`:
  - Assert `crc_enable` and push the byte into the 2-deep holdback buffer.
  - If the buffer was already full, the oldest byte is written to the FIFO (`w_enable`, `w_data`) and the payload count increments.
  - Write needed while `fifo_full` goes to ERR with no write.
  - Count would exceed `MAX_DATA` goes to ERR.
- RCV_DATA, on `eop_strobe`:
  - Buffer not full (fewer than 2 bytes since PID) goes to ERR.
  - Otherwise go to CHECK_CRC. Buffered bytes are the CRC and are discarded.
- CHECK_CRC (1 cycle): `crc_value` == `CRC_RESIDUE` goes to DONE; otherwise ERR.
- WAIT_EOP (handshake): `eop_strobe` goes to DONE; `byte_received` goes to ERR.
- DONE: pulse `rx_data_ready`, latch `rx_byte_count` (0 for ACK/NAK), drop `rcving`, go to IDLE.
- ERR: set `r_error`. Wait for `eop` low, then go to IDLE. `r_error` holds until the next `d_edge` in IDLE.
- Simultaneous `byte_received` and `eop_strobe`: the byte is processed first. EOP is handled on the next `eop_strobe` (SE0 lasts 2 bit times).

## Timing
- `w_enable`, `crc_enable`: registered, asserted the cycle after `byte_received`.
- `rx_data_ready`: 2 cycles after the accepting `eop_strobe` for DATA packets, 1 cycle for handshake packets.
- `r_error`: rises the cycle after the detecting event.
- Minimum gap between `byte_received` pulses: 8 `shift_enable` periods. Back-to-back packets need IDLE re-entry before `d_edge`.
- `n_rst` asserted mid-packet: immediate return to reset values. No partial write completes.

## Configuration
- `USB_RX_TIMEOUT_EN` defined: a counter resets on every `byte_received` and runs in WAIT_SYNC, WAIT_PID, RCV_DATA and WAIT_EOP. Reaching `TIMEOUT_CYCLES` goes to ERR, then straight to IDLE.
- Undefined: no counter; states wait indefinitely.

## Structure
- `usb_pkg`, shared with `tcu`: `SYNC_BYTE`, `PID_DATA`, `PID_ACK`, `PID_NAK`, the `rx_packet` encoding enum, `CRC_RESIDUE` default.
- State enum local to the module.
- Sub-module `usb_rx_holdback`: 2-deep byte shift buffer with valid count, `push`, `flush` and `full` outputs, and `oldest` data.

## Test plan
- SYNC, PID 0x3C, payload 0x11 0x22 0x33, correct CRC, EOP -> three `w_enable` pulses with 0x11, 0x22, 0x33; `rx_data_ready`=1; `rx_packet`=1; `rx_byte_count`=3; `r_error`=0.
- SYNC, PID 0x2D, EOP -> no writes; `rx_packet`=2; `rx_data_ready` pulse. Same with PID 0xA5 -> `rx_packet`=3.
- SYNC, 0x3C, CRC-only (2 bytes), EOP -> `rx_byte_count`=0, good. 0x3C plus 1 byte, EOP -> `r_error`=1.
- Corrupted CRC byte -> payload written, `r_error`=1, no `rx_data_ready`. Next `d_edge` clears `r_error`.
- Bad SYNC 0x81, or PID 0x69 -> `r_error`=1, no writes. `fifo_full`=1 at third payload byte -> ERR, write count 0.
- `n_rst` mid-payload -> all outputs 0 next cycle. With `USB_RX_TIMEOUT_EN`, a stall of 255 cycles after PID -> `r_error`=1.
